// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART_TX handshake bundle for the round-robin UART_TX arbiter.
// The arbiter connects through the slave modport; requesters and the UART side connect through master.
interface uart_tx_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   Req;
  logic [8*N-1:0] Req_Data;
  logic [N-1:0]   Lock;
  logic [N-1:0]   Ack;
  logic [N-1:0]   Err;
  logic [N-1:0]   Grant;
  logic [7:0]     TX_Data_In;
  logic           TX_Data_Ready;
  logic           TX_Data_Send;
  logic           TX_UBusy;
  logic           Busy;

  modport master (
    output Req, Req_Data, Lock, TX_UBusy,
    input  Ack, Err, Grant, TX_Data_In, TX_Data_Ready, TX_Data_Send, Busy
  );

  modport slave (
    input  Req, Req_Data, Lock, TX_UBusy,
    output Ack, Err, Grant, TX_Data_In, TX_Data_Ready, TX_Data_Send, Busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_TX among N byte requesters, with lock
// bursts, per-byte acknowledge and a start-of-transmission timeout.
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16,
  parameter int TW      = 5
) (
  input logic               Clk,
  input logic               RST,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, ARB, LOAD, SEND, WAIT_LO} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] next_idx;
  logic          win_found;
  logic          lock_flag;
  logic [TW-1:0] tcnt;
  logic [N-1:0]  grant;
  logic [N-1:0]  ack;
  logic [N-1:0]  err;
  logic [7:0]    data_in;
  logic          data_ready;
  logic          data_send;
  logic          busy;

  // A locked owner that still requests keeps the channel; otherwise scan from ptr.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    if (lock_flag && bus.Req[owner]) begin
      win_found = 1'b1;
      win_idx   = owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!win_found && bus.Req[(int'(ptr) + k) % N]) begin
          win_found = 1'b1;
          win_idx   = IW'((int'(ptr) + k) % N);
        end
      end
    end
  end

  assign next_idx = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      lock_flag  <= 1'b0;
      tcnt       <= '0;
      grant      <= '0;
      ack        <= '0;
      err        <= '0;
      data_in    <= '0;
      data_ready <= 1'b0;
      data_send  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        IDLE: begin
          if (|bus.Req) begin
            state <= ARB;
            busy  <= 1'b1;
          end
        end
        ARB: begin
          if (win_found) begin
            owner      <= win_idx;
            grant      <= N'(1) << win_idx;
            data_in    <= bus.Req_Data[8*win_idx +: 8];
            data_ready <= 1'b1;
            state      <= LOAD;
          end else begin
            grant <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        LOAD: begin
          data_ready <= 1'b0;
          data_send  <= 1'b1;
          tcnt       <= '0;
          state      <= SEND;
        end
        SEND: begin
          if (bus.TX_UBusy) begin
            data_send <= 1'b0;
            state     <= WAIT_LO;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            // The transmitter never started: drop the byte and release the channel.
            data_send <= 1'b0;
            err       <= grant;
            grant     <= '0;
            lock_flag <= 1'b0;
            ptr       <= next_idx;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!bus.TX_UBusy) begin
            ack       <= grant;
            grant     <= '0;
            ptr       <= next_idx;
            lock_flag <= bus.Lock[owner];
            busy      <= |bus.Req;
            state     <= (|bus.Req) ? ARB : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Ack           = ack;
  assign bus.Err           = err;
  assign bus.Grant         = grant;
  assign bus.TX_Data_In    = data_in;
  assign bus.TX_Data_Ready = data_ready;
  assign bus.TX_Data_Send  = data_send;
  assign bus.Busy          = busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte-queue requesters, a UART_TX stub, a transaction-level
// model checked every cycle, and directed scenarios with hand-computed expectations.
module tb_uart_tx_arbiter;
  localparam int N       = 4;
  localparam int TIMEOUT = 16;

  typedef struct {
    int         id;
    logic [7:0] data;
    bit         is_err;
    int         load_cyc;
    int         end_cyc;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   n_loads;

  uart_tx_arbiter_if #(.N(N)) bus ();

  uart_tx_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .TW(5)) dut (
    .Clk (clk),
    .RST (rst_n),
    .bus (bus)
  );

  // Requester byte queues, UART stub controls and the completion log
  logic [7:0] rq_data [N][8];
  bit         rq_lock [N][8];
  int         rq_len  [N];
  int         rq_pos  [N];
  int         rise_cyc[N];
  logic [N-1:0] pulse;
  bit         stub_dead;
  int         stub_delay;
  int         stub_hold;
  ev_t        done_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    oh = '0;
    if (i >= 0 && i < N) oh[i] = 1'b1;
  endfunction

  // Winner per the arbitration rules: locked owner first, else first requester from ptr.
  function automatic int pick(input logic [N-1:0] r, input int p, input bit lk, input int own);
    if (lk && r[own]) return own;
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      rq_len[i] = 0;
      rq_pos[i] = 0;
    end
    pulse = '0;
  endtask

  task automatic add(input int id, input logic [7:0] d, input bit lk);
    rq_data[id][rq_len[id]] = d;
    rq_lock[id][rq_len[id]] = lk;
    rq_len[id]++;
  endtask

  task automatic wait_done(input int k, input int budget, input string nm);
    int c;
    c = 0;
    while (done_q.size() < k && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({nm, "_done"}, 32'(done_q.size() >= k), 32'd1);
  endtask

  task automatic check_ev(input int i, input int id, input logic [7:0] d, input bit e, input string nm);
    if (i >= done_q.size()) begin
      check({nm, "_count"}, done_q.size(), i + 1);
    end else begin
      check({nm, "_id"}, done_q[i].id, id);
      check({nm, "_data"}, done_q[i].data, d);
      check({nm, "_err"}, 32'(done_q[i].is_err), 32'(e));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_queues();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_q.delete();
  endtask

  // Requesters: present the head byte, advance on Ack/Err, drop Req when empty.
  initial begin
    bus.Req      = '0;
    bus.Req_Data = '0;
    bus.Lock     = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rst_n && (bus.Ack[i] || bus.Err[i]) && rq_pos[i] < rq_len[i]) rq_pos[i]++;
        if (rq_pos[i] < rq_len[i]) begin
          if (!bus.Req[i]) rise_cyc[i] = cyc;
          bus.Req[i]              = 1'b1;
          bus.Req_Data[8*i +: 8]  = rq_data[i][rq_pos[i]];
          bus.Lock[i]             = rq_lock[i][rq_pos[i]];
        end else begin
          bus.Req[i]  = 1'b0;
          bus.Lock[i] = 1'b0;
        end
      end
      bus.Req = bus.Req | pulse;
      pulse   = '0;
    end
  end

  // UART_TX stub: UBusy rises stub_delay cycles after Send and stays up stub_hold cycles.
  initial begin
    int ph;
    int sc;
    ph = 0;
    sc = 0;
    bus.TX_UBusy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.TX_UBusy = 1'b0;
        ph = 0;
      end else begin
        case (ph)
          0: if (bus.TX_Data_Send && !stub_dead) begin sc = stub_delay; ph = 1; end
          1: begin sc--; if (sc == 0) begin bus.TX_UBusy = 1'b1; sc = stub_hold; ph = 2; end end
          2: begin sc--; if (sc == 0) begin bus.TX_UBusy = 1'b0; ph = 3; end end
          default: if (!bus.TX_Data_Send) ph = 0;
        endcase
      end
    end
  end

  // Transaction model and per-cycle compare
  initial begin
    int m_ptr, m_owner, m_cnt, m_load_cyc, w;
    bit m_lock, m_active, m_in_send, m_started, m_just_loaded;
    bit exp_ack, exp_err, exp_busy, lock_next;
    logic [7:0] m_byte;
    logic [N-1:0] req_last;
    logic [8*N-1:0] data_last;
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_load_cyc = 0; m_lock = 0; m_active = 0;
    m_in_send = 0; m_started = 0; m_just_loaded = 0; exp_ack = 0; exp_err = 0;
    exp_busy = 0; lock_next = 0; m_byte = '0; req_last = '0; data_last = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_outputs", {bus.Grant, bus.Ack, bus.Err, bus.TX_Data_In, bus.TX_Data_Ready,
                              bus.TX_Data_Send, bus.Busy}, 32'd0);
        m_ptr = 0; m_owner = 0; m_lock = 0; m_active = 0; m_in_send = 0; m_started = 0;
        m_just_loaded = 0; exp_ack = 0; exp_err = 0;
      end else begin
        if (exp_ack) begin
          check("m_ack", bus.Ack, oh(m_owner));
          check("m_ack_err", bus.Err, 0);
          check("m_ack_busy", bus.Busy, exp_busy);
          done_q.push_back('{m_owner, m_byte, 1'b0, m_load_cyc, cyc});
          m_active = 0; m_ptr = (m_owner + 1) % N; m_lock = lock_next; exp_ack = 0;
        end else if (exp_err) begin
          check("m_err", bus.Err, oh(m_owner));
          check("m_err_ack", bus.Ack, 0);
          done_q.push_back('{m_owner, m_byte, 1'b1, m_load_cyc, cyc});
          m_active = 0; m_ptr = (m_owner + 1) % N; m_lock = 0; exp_err = 0;
        end else begin
          check("m_no_ack", bus.Ack, 0);
          check("m_no_err", bus.Err, 0);
        end
        if (!m_active && bus.TX_Data_Ready) begin
          w = pick(req_last, m_ptr, m_lock, m_owner);
          check("m_load_grant", bus.Grant, oh(w));
          m_owner = (w < 0) ? 0 : w;
          m_byte = data_last[8*m_owner +: 8];
          m_active = 1; m_just_loaded = 1; m_in_send = 0; m_started = 0; m_cnt = 0;
          m_load_cyc = cyc;
          n_loads++;
        end
        if (m_active) begin
          check("m_grant", bus.Grant, oh(m_owner));
          check("m_data", bus.TX_Data_In, m_byte);
          check("m_busy", bus.Busy, 1);
          check("m_ready", bus.TX_Data_Ready, m_just_loaded);
          check("m_send", bus.TX_Data_Send, m_in_send);
          if (m_just_loaded) begin
            m_in_send = 1;
          end else if (m_in_send) begin
            if (bus.TX_UBusy) begin
              m_in_send = 0; m_started = 1;
            end else begin
              m_cnt++;
              if (m_cnt == TIMEOUT) begin m_in_send = 0; exp_err = 1; end
            end
          end else if (m_started && !bus.TX_UBusy) begin
            exp_ack = 1; lock_next = bus.Lock[m_owner]; exp_busy = |bus.Req;
          end
        end else begin
          check("m_idle_grant", bus.Grant, 0);
          check("m_idle_ready", bus.TX_Data_Ready, 0);
          check("m_idle_send", bus.TX_Data_Send, 0);
        end
        m_just_loaded = 0;
      end
      req_last  = bus.Req;
      data_last = bus.Req_Data;
    end
  end

  // Directed scenarios
  initial begin
    int n0, bc, c;
    n_cmp = 0; n_bad = 0; n_loads = 0;
    rst_n = 1'b0; stub_dead = 0; stub_delay = 2; stub_hold = 10;
    clear_queues();
    for (int i = 0; i < N; i++) rise_cyc[i] = 0;
    repeat (3) @(negedge clk);
    check("reset_grant", bus.Grant, 0);
    check("reset_busy", bus.Busy, 0);
    check("reset_data", bus.TX_Data_In, 0);
    check("reset_ready", bus.TX_Data_Ready, 0);
    check("reset_send", bus.TX_Data_Send, 0);
    check("reset_ack", bus.Ack, 0);
    check("reset_err", bus.Err, 0);
    rst_n = 1'b1;

    // Single request
    @(negedge clk);
    add(0, 8'hDB, 0);
    wait_done(1, 100, "single");
    repeat (3) @(negedge clk);
    check("single_acks", done_q.size(), 1);
    check_ev(0, 0, 8'hDB, 0, "single");
    if (done_q.size() >= 1) begin
      check("single_latency", done_q[0].load_cyc - rise_cyc[0], 2);
      check("single_ack_cyc", done_q[0].end_cyc - done_q[0].load_cyc, 14);
    end
    check("single_busy_end", bus.Busy, 0);

    // Round robin from requester 0 priority
    do_reset();
    add(0, 8'h10, 0); add(1, 8'h21, 0); add(2, 8'h32, 0); add(3, 8'h43, 0); add(0, 8'h54, 0);
    wait_done(5, 300, "rr");
    check_ev(0, 0, 8'h10, 0, "rr0");
    check_ev(1, 1, 8'h21, 0, "rr1");
    check_ev(2, 2, 8'h32, 0, "rr2");
    check_ev(3, 3, 8'h43, 0, "rr3");
    check_ev(4, 0, 8'h54, 0, "rr4");

    // Lock burst from requester 2 while requester 0 waits
    done_q.delete();
    add(2, 8'hA0, 1); add(2, 8'hA1, 1); add(2, 8'hA2, 0); add(0, 8'h05, 0);
    wait_done(4, 300, "lock");
    check_ev(0, 2, 8'hA0, 0, "lock0");
    check_ev(1, 2, 8'hA1, 0, "lock1");
    check_ev(2, 2, 8'hA2, 0, "lock2");
    check_ev(3, 0, 8'h05, 0, "lock3");

    // Timeout on requester 1, then requester 2 served
    done_q.delete();
    stub_dead = 1;
    add(1, 8'h77, 0); add(2, 8'h88, 0);
    wait_done(1, 100, "tmo");
    stub_dead = 0;
    wait_done(2, 200, "tmo_next");
    check_ev(0, 1, 8'h77, 1, "tmo0");
    check_ev(1, 2, 8'h88, 0, "tmo1");
    if (done_q.size() >= 1) check("tmo_cycles", done_q[0].end_cyc - done_q[0].load_cyc, 17);

    // Reset while waiting for UBusy to fall
    done_q.delete();
    add(3, 8'h3C, 0);
    c = 0;
    while (!bus.TX_UBusy && c < 100) begin @(negedge clk); c++; end
    check("rst_wait_ubusy", bus.TX_UBusy, 1);
    @(posedge clk);
    #2;
    check("pre_rst_grant", bus.Grant, 4'b1000);
    check("pre_rst_busy", bus.Busy, 1);
    rst_n = 1'b0;
    clear_queues();
    #1;
    check("async_grant", bus.Grant, 0);
    check("async_send", bus.TX_Data_Send, 0);
    check("async_ack", bus.Ack, 0);
    check("async_busy", bus.Busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_q.delete();
    add(3, 8'h3D, 0); add(0, 8'h5A, 0);
    wait_done(2, 200, "post_rst");
    check_ev(0, 0, 8'h5A, 0, "post_rst0");
    check_ev(1, 3, 8'h3D, 0, "post_rst1");

    // One-cycle request pulse in IDLE is withdrawn before arbitration
    done_q.delete();
    repeat (3) @(negedge clk);
    n0 = n_loads;
    bc = 0;
    pulse = 4'b0010;
    repeat (8) begin
      @(negedge clk);
      if (bus.Busy) bc++;
    end
    check("wd_loads", n_loads - n0, 0);
    check("wd_busy_cycles", bc, 1);
    check("wd_done", done_q.size(), 0);
    check("wd_busy_end", bus.Busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
